fft_start_gen: RTL and testbench

- Multi-channel frame-start generator for the burst FFT/IFFT path.
- Issues a one-cycle fft_start pulse per channel:
  - once after reset release;
  - after every completed input frame (valid & last).
- Enforces a minimum spacing between starts, with a one-deep pending slot.
- Checks each frame for the exact length 2^(ADDR_WIDTH+1) and flags errors.
- Sits between the per-channel AXI-stream input framers and the FFT core start inputs.

---
 rtl/fft_start_gen.sv | 162 ++++++++++++++++
 tb/tb_fft_start_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_start_gen.sv
// ---------------------------------------------------------------------------
// fft_start_gen
// Multi-channel frame-start generator for the burst FFT/IFFT path. Each
// channel gets a registered one-cycle fft_start pulse once after reset
// release and after every completed input frame (valid & last). Pulses on a
// channel are kept at least START_GAP cycles apart; one trigger that arrives
// too early is held in a pending slot, and a further one is dropped.
// Every frame is checked for exactly 2^(ADDR_WIDTH+1) beats.
//
// Ports:
//   clk          single clock
//   rst          asynchronous active-high reset
//   enable       global trigger enable (beat counting/checking continues)
//   m_axi_valid  per-channel input beat valid
//   m_axi_last   per-channel last beat of frame (qualified by valid)
//   err_clr      synchronous clear of all sticky error bits
//   fft_start    registered one-cycle start pulse per channel
//   len_err      sticky: frame length mismatch
//   ovf_err      sticky: trigger dropped because the pending slot was full
// ---------------------------------------------------------------------------
module fft_start_gen #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 9,
  parameter int RST_DLY    = 3,
  parameter int START_GAP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_CH-1:0] m_axi_valid,
  input  logic [NUM_CH-1:0] m_axi_last,
  input  logic              err_clr,
  output logic [NUM_CH-1:0] fft_start,
  output logic [NUM_CH-1:0] len_err,
  output logic [NUM_CH-1:0] ovf_err
);

  localparam int              CNT_W      = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = '1;
  localparam logic [7:0]      GAP_RELOAD = 8'(START_GAP - 1);
  localparam logic [3:0]      INIT_EDGE  = 4'(RST_DLY - 2);

  typedef enum logic [1:0] {
    READY,
    GAP,
    PEND
  } chState_e;

  logic [3:0]        initCnt_q;
  logic              initFired_q;
  logic              initTrig_q;
  logic [NUM_CH-1:0] start_q;
  logic [NUM_CH-1:0] lenErr_q;
  logic [NUM_CH-1:0] ovfErr_q;

  assign fft_start = start_q;
  assign len_err   = lenErr_q;
  assign ovf_err   = ovfErr_q;

  // Init sequencer: counts edges after reset release and raises initTrig on
  // edge RST_DLY-1 so that the channel FSMs register the start on edge
  // RST_DLY. initTrig is held until enable is seen high, then retired; the
  // fired flag guarantees a single init trigger per reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      initCnt_q   <= '0;
      initFired_q <= 1'b0;
      initTrig_q  <= 1'b0;
    end else if (!initFired_q) begin
      initCnt_q <= initCnt_q + 4'd1;
      if (initCnt_q == INIT_EDGE) begin
        initTrig_q  <= 1'b1;
        initFired_q <= 1'b1;
      end
    end else if (initTrig_q && enable) begin
      initTrig_q <= 1'b0;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    chState_e         state_q, state_d;
    logic [7:0]       gapCnt_q, gapCnt_d;
    logic [CNT_W-1:0] beatCnt_q;
    logic             start_d;
    logic             ovfSet;
    logic             lenSet;
    logic             trig;

    // Init and frame triggers landing together merge into one trigger.
    assign trig = enable & ((m_axi_valid[ch] & m_axi_last[ch]) | initTrig_q);

    // A frame is wrong if last comes early, or if the final beat position is
    // reached without last (the counter then simply wraps to zero).
    assign lenSet = m_axi_valid[ch] & (m_axi_last[ch] ^ (beatCnt_q == LAST_IDX));

    // Spacing FSM. GAP with the counter already at zero behaves like READY,
    // so a trigger in that cycle is launched without a pending detour.
    always_comb begin
      state_d  = state_q;
      gapCnt_d = gapCnt_q;
      start_d  = 1'b0;
      ovfSet   = 1'b0;
      unique case (state_q)
        READY: begin
          if (trig) begin
            start_d  = 1'b1;
            gapCnt_d = GAP_RELOAD;
            state_d  = (START_GAP > 1) ? GAP : READY;
          end
        end
        GAP: begin
          if (gapCnt_q == 8'd0) begin
            if (trig) begin
              start_d  = 1'b1;
              gapCnt_d = GAP_RELOAD;
              state_d  = (START_GAP > 1) ? GAP : READY;
            end else begin
              state_d = READY;
            end
          end else begin
            gapCnt_d = gapCnt_q - 8'd1;
            if (trig) state_d = PEND;
          end
        end
        PEND: begin
          ovfSet = trig;
          if (gapCnt_q == 8'd0) begin
            start_d  = 1'b1;
            gapCnt_d = GAP_RELOAD;
            state_d  = (START_GAP > 1) ? GAP : READY;
          end else begin
            gapCnt_d = gapCnt_q - 8'd1;
          end
        end
        default: state_d = READY;
      endcase
    end

    // Channel registers: FSM, start pulse, beat counter and sticky errors.
    // A new error event in the same cycle as err_clr keeps the bit set.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q      <= READY;
        gapCnt_q     <= '0;
        beatCnt_q    <= '0;
        start_q[ch]  <= 1'b0;
        lenErr_q[ch] <= 1'b0;
        ovfErr_q[ch] <= 1'b0;
      end else begin
        state_q      <= state_d;
        gapCnt_q     <= gapCnt_d;
        start_q[ch]  <= start_d;
        lenErr_q[ch] <= (lenErr_q[ch] & ~err_clr) | lenSet;
        ovfErr_q[ch] <= (ovfErr_q[ch] & ~err_clr) | ovfSet;
        if (m_axi_valid[ch]) begin
          beatCnt_q <= m_axi_last[ch] ? '0 : beatCnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_start_gen.sv
// ---------------------------------------------------------------------------
// tb_fft_start_gen
// Directed bench for fft_start_gen with default parameters (2 channels,
// 1024-point frames, RST_DLY=3, START_GAP=4). Expected start pulses are
// queued as (edge index, channel mask) when stimulus is issued; a monitor
// pops and compares each time the DUT raises fft_start. Sticky error bits
// are compared against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fft_start_gen;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] mAxiValid;
  logic [1:0] mAxiLast;
  logic       errClr;
  logic [1:0] fftStart;
  logic [1:0] lenErr;
  logic [1:0] ovfErr;

  typedef struct {
    int         edgeIdx;
    logic [1:0] mask;
  } expPulse_t;

  expPulse_t expQ[$];
  int        cyc = 0;
  int        nVec = 0;
  int        nErr = 0;
  int        t;

  fft_start_gen #(
    .NUM_CH    (2),
    .ADDR_WIDTH(9),
    .RST_DLY   (3),
    .START_GAP (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .m_axi_valid(mAxiValid),
    .m_axi_last (mAxiLast),
    .err_clr    (errClr),
    .fft_start  (fftStart),
    .len_err    (lenErr),
    .ovf_err    (ovfErr)
  );

  // 10 ns clock; cyc holds the index of the most recent rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: every cycle with a start pulse must match the queue head.
  always @(negedge clk) begin
    if (fftStart != 2'b00) begin
      nVec++;
      if (expQ.size() == 0) begin
        nErr++;
        $display("[TB] FAIL pulse: unexpected fft_start=%b at edge %0d, none required", fftStart, cyc);
      end else begin
        expPulse_t e;
        e = expQ.pop_front();
        if (e.edgeIdx != cyc || e.mask != fftStart) begin
          nErr++;
          $display("[TB] FAIL pulse: got fft_start=%b at edge %0d, required %b at edge %0d",
                   fftStart, cyc, e.mask, e.edgeIdx);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic expectPulse(input int edgeIdx, input logic [1:0] mask);
    expPulse_t e;
    e.edgeIdx = edgeIdx;
    e.mask    = mask;
    expQ.push_back(e);
  endtask

  // Sends one frame of nBeats consecutive beats on channel ch; the last beat
  // carries last. When doExpect is set, a start pulse is expected on the
  // edge that samples the last beat.
  task automatic applyStimulus(input int ch, input int nBeats, input bit doExpect);
    for (int i = 0; i < nBeats; i++) begin
      @(negedge clk);
      mAxiValid     = 2'b00;
      mAxiLast      = 2'b00;
      mAxiValid[ch] = 1'b1;
      mAxiLast[ch]  = (i == nBeats - 1);
      if (i == nBeats - 1 && doExpect) expectPulse(cyc + 1, 2'(1 << ch));
    end
    @(negedge clk);
    mAxiValid = 2'b00;
    mAxiLast  = 2'b00;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] expLen, input logic [1:0] expOvf);
    nVec++;
    if (lenErr !== expLen) begin
      nErr++;
      $display("[TB] FAIL %s len_err: got %b, required %b", name, lenErr, expLen);
    end
    nVec++;
    if (ovfErr !== expOvf) begin
      nErr++;
      $display("[TB] FAIL %s ovf_err: got %b, required %b", name, ovfErr, expOvf);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseErrClr();
    @(negedge clk);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b1;
    mAxiValid = 2'b00;
    mAxiLast  = 2'b00;
    errClr    = 1'b0;
    idle(3);
    nVec++;
    if (fftStart !== 2'b00) begin
      nErr++;
      $display("[TB] FAIL reset fft_start: got %b, required 00", fftStart);
    end
    checkOutput("reset", 2'b00, 2'b00);

    // Init pulse on all channels registered on the third edge after release.
    $display("[TB] init after reset release");
    @(negedge clk);
    rst = 1'b0;
    expectPulse(cyc + 3, 2'b11);
    idle(12);
    checkOutput("init", 2'b00, 2'b00);

    // Clean 1024-beat frame on ch0.
    $display("[TB] ch0 full frame");
    applyStimulus(0, 1024, 1'b1);
    idle(8);
    checkOutput("ch0 frame", 2'b00, 2'b00);

    // Short frame on ch1, then a clean frame, then clear.
    $display("[TB] ch1 short frame");
    applyStimulus(1, 500, 1'b1);
    idle(8);
    checkOutput("ch1 short", 2'b10, 2'b00);
    applyStimulus(1, 1024, 1'b1);
    idle(8);
    checkOutput("ch1 clean sticky", 2'b10, 2'b00);
    pulseErrClr();
    idle(2);
    checkOutput("ch1 cleared", 2'b00, 2'b00);
    applyStimulus(1, 1024, 1'b1);
    idle(8);
    checkOutput("ch1 clean again", 2'b00, 2'b00);

    // ch0 single-beat lasts at edges t, t+2, t+3: pulses t and t+4,
    // third trigger dropped.
    $display("[TB] ch0 spacing and overflow");
    @(negedge clk);
    t = cyc + 1;
    expectPulse(t, 2'b01);
    expectPulse(t + 4, 2'b01);
    mAxiValid = 2'b01; mAxiLast = 2'b01;
    @(negedge clk);
    mAxiValid = 2'b00; mAxiLast = 2'b00;
    @(negedge clk);
    mAxiValid = 2'b01; mAxiLast = 2'b01;
    @(negedge clk);
    @(negedge clk);
    mAxiValid = 2'b00; mAxiLast = 2'b00;
    idle(10);
    checkOutput("ch0 overflow", 2'b01, 2'b01);
    pulseErrClr();
    idle(2);
    checkOutput("ch0 cleared", 2'b00, 2'b00);

    // ch1 triggers exactly START_GAP apart: both issued without pending.
    $display("[TB] ch1 trigger on gap expiry");
    @(negedge clk);
    t = cyc + 1;
    expectPulse(t, 2'b10);
    expectPulse(t + 4, 2'b10);
    mAxiValid = 2'b10; mAxiLast = 2'b10;
    @(negedge clk);
    mAxiValid = 2'b00; mAxiLast = 2'b00;
    idle(3);
    mAxiValid = 2'b10; mAxiLast = 2'b10;
    @(negedge clk);
    mAxiValid = 2'b00; mAxiLast = 2'b00;
    idle(10);
    checkOutput("ch1 gap expiry", 2'b10, 2'b00);
    pulseErrClr();

    // Error event and err_clr in the same cycle: set wins.
    $display("[TB] set wins over clear");
    idle(6);
    @(negedge clk);
    expectPulse(cyc + 1, 2'b01);
    mAxiValid = 2'b01; mAxiLast = 2'b01; errClr = 1'b1;
    @(negedge clk);
    mAxiValid = 2'b00; mAxiLast = 2'b00; errClr = 1'b0;
    checkOutput("set wins", 2'b01, 2'b00);
    @(negedge clk);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    checkOutput("clear alone", 2'b00, 2'b00);

    // Reset again, release with enable low; frame trigger is not replayed
    // but its short length is still flagged.
    $display("[TB] init held by enable");
    idle(8);
    rst    = 1'b1;
    enable = 1'b0;
    idle(3);
    checkOutput("second reset", 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    mAxiValid = 2'b10; mAxiLast = 2'b10;
    @(negedge clk);
    mAxiValid = 2'b00; mAxiLast = 2'b00;
    idle(6);
    @(negedge clk);
    enable = 1'b1;
    expectPulse(cyc + 1, 2'b11);
    idle(12);
    checkOutput("enable late", 2'b10, 2'b00);

    nVec++;
    if (expQ.size() != 0) begin
      nErr++;
      $display("[TB] FAIL pending pulses: got %0d still queued, required 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
